// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard/stall controller
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      LSTALL = 2'd1,
      FREEZE = 2'd2
   } state_e;

   localparam int AW_DEF    = 5;
   localparam int CNT_W_DEF = 16;

   // Width of the remaining-bubble counter; it must hold LOAD_LAT-1
   function automatic int rem_width(input int load_lat);
      int w;
      w = $clog2(load_lat);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/hazard_src_match.sv
// rtl/hazard_src_match.sv - compares the load destination against every live IF/ID source
module hazard_src_match #(
   parameter int AW      = 5,
   parameter int NUM_SRC = 2
) (
   input  logic [AW-1:0]         rt_i,
   input  logic [NUM_SRC*AW-1:0] src_i,
   input  logic [NUM_SRC-1:0]    src_valid_i,
   output logic                  match_o
);

   // Any valid source equal to the load target is a hit; register 0 never is
   always_comb begin
      match_o = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (src_valid_i[k] && (src_i[k*AW +: AW] == rt_i)) begin
            match_o = 1'b1;
         end
      end
      if (rt_i == '0) begin
         match_o = 1'b0;
      end
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - ID-stage load-use stall, freeze and branch-flush controller
module hazard_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int AW       = AW_DEF,
   parameter int NUM_SRC  = 2,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  idex_memread_i,
   input  logic [AW-1:0]         idex_rt_i,
   input  logic [NUM_SRC*AW-1:0] ifid_src_i,
   input  logic [NUM_SRC-1:0]    ifid_src_valid_i,
   input  logic                  branch_taken_i,
   input  logic                  mem_stall_i,
   output logic                  pc_write_o,
   output logic                  ifid_write_o,
   output logic                  bubble_o,
   output logic                  ifid_flush_o,
   output logic [CNT_W-1:0]      stall_cnt_o
);

   localparam int            RW       = rem_width(LOAD_LAT);
   localparam logic [RW-1:0] REM_LOAD = RW'(LOAD_LAT - 1);
   localparam logic [RW-1:0] REM_ONE  = RW'(1);

   state_e           state_q, state_d, cur_state;
   logic [RW-1:0]    rem_q, rem_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             src_hit;
   logic             hz;

   hazard_src_match #(
      .AW      (AW),
      .NUM_SRC (NUM_SRC)
   ) u_src_match (
      .rt_i        (idex_rt_i),
      .src_i       (ifid_src_i),
      .src_valid_i (ifid_src_valid_i),
      .match_o     (src_hit)
   );

   assign hz          = idex_memread_i && src_hit;
   assign stall_cnt_o = cnt_q;

   // Next state, bubble countdown and pipeline control; a frozen cycle resumes whatever rem implies
   always_comb begin
      state_d      = state_q;
      rem_d        = rem_q;
      pc_write_o   = 1'b1;
      ifid_write_o = 1'b1;
      bubble_o     = 1'b0;
      ifid_flush_o = 1'b0;
      cur_state    = state_q;
      if (state_q == FREEZE) begin
         cur_state = (rem_q != '0) ? LSTALL : RUN;
      end

      if (rst_i) begin
         state_d = RUN;
         rem_d   = '0;
      end else if (mem_stall_i) begin
         pc_write_o   = 1'b0;
         ifid_write_o = 1'b0;
         state_d      = FREEZE;
      end else if (cur_state == LSTALL) begin
         pc_write_o   = 1'b0;
         ifid_write_o = 1'b0;
         bubble_o     = 1'b1;
         rem_d        = rem_q - REM_ONE;
         state_d      = (rem_q == REM_ONE) ? RUN : LSTALL;
      end else if (hz) begin
         pc_write_o   = 1'b0;
         ifid_write_o = 1'b0;
         bubble_o     = 1'b1;
         if (LOAD_LAT > 1) begin
            rem_d   = REM_LOAD;
            state_d = LSTALL;
         end else begin
            state_d = RUN;
         end
      end else begin
         state_d      = RUN;
         ifid_flush_o = branch_taken_i;
      end
   end

   // Saturating count of bubble cycles
   always_comb begin
      cnt_d = cnt_q;
      if (bubble_o && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RUN;
         rem_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst, rd, br, ms;
   logic [4:0]  rt, s0, s1;
   logic [1:0]  v;
   logic [2:0]  pcw, ifw, bub, fl;
   logic [15:0] cnt0, cnt1;
   logic [1:0]  cnt2;

   int checks = 0;
   int errors = 0;

   int lat  [3] = '{1, 3, 1};
   int cmax [3] = '{65535, 65535, 3};
   int pend [3];
   int mcnt [3];

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.AW(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(16)) u_l1 (
      .clk_i(clk), .rst_i(rst), .idex_memread_i(rd), .idex_rt_i(rt),
      .ifid_src_i({s1, s0}), .ifid_src_valid_i(v), .branch_taken_i(br), .mem_stall_i(ms),
      .pc_write_o(pcw[0]), .ifid_write_o(ifw[0]), .bubble_o(bub[0]), .ifid_flush_o(fl[0]),
      .stall_cnt_o(cnt0));

   hazard_stall_ctrl #(.AW(5), .NUM_SRC(2), .LOAD_LAT(3), .CNT_W(16)) u_l3 (
      .clk_i(clk), .rst_i(rst), .idex_memread_i(rd), .idex_rt_i(rt),
      .ifid_src_i({s1, s0}), .ifid_src_valid_i(v), .branch_taken_i(br), .mem_stall_i(ms),
      .pc_write_o(pcw[1]), .ifid_write_o(ifw[1]), .bubble_o(bub[1]), .ifid_flush_o(fl[1]),
      .stall_cnt_o(cnt1));

   hazard_stall_ctrl #(.AW(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(2)) u_sat (
      .clk_i(clk), .rst_i(rst), .idex_memread_i(rd), .idex_rt_i(rt),
      .ifid_src_i({s1, s0}), .ifid_src_valid_i(v), .branch_taken_i(br), .mem_stall_i(ms),
      .pc_write_o(pcw[2]), .ifid_write_o(ifw[2]), .bubble_o(bub[2]), .ifid_flush_o(fl[2]),
      .stall_cnt_o(cnt2));

   typedef struct {
      logic       rst, rd;
      logic [4:0] rt, s0, s1;
      logic [1:0] v;
      logic       br, ms;
      logic       pc, iw, bb, fl;
      int         cnt;
   } vec_t;

   vec_t tbl [9];

   function automatic vec_t mk(input logic r, input logic d, input int t, input int a, input int b,
                               input int vv, input logic bt, input logic m,
                               input logic pc, input logic iw, input logic bb, input logic f, input int c);
      vec_t x;
      x.rst = r; x.rd = d; x.rt = 5'(t); x.s0 = 5'(a); x.s1 = 5'(b); x.v = 2'(vv);
      x.br = bt; x.ms = m; x.pc = pc; x.iw = iw; x.bb = bb; x.fl = f; x.cnt = c;
      return x;
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic set_in(input logic r, input logic d, input int t, input int a, input int b,
                         input int vv, input logic bt, input logic m);
      rst = r; rd = d; rt = 5'(t); s0 = 5'(a); s1 = 5'(b); v = 2'(vv); br = bt; ms = m;
   endtask

   // Reference: a load-use hazard owes LOAD_LAT bubbles; freeze cycles pause the debt
   task automatic pre();
      bit hzm;
      int e_pc, e_iw, e_bb, e_fl;
      #1;
      hzm = rd && (rt != 0) && ((v[0] && s0 == rt) || (v[1] && s1 == rt));
      for (int i = 0; i < 3; i++) begin
         e_pc = 1; e_iw = 1; e_bb = 0; e_fl = 0;
         if (rst) begin
         end else if (ms) begin
            e_pc = 0; e_iw = 0;
         end else if (pend[i] > 0 || hzm) begin
            e_pc = 0; e_iw = 0; e_bb = 1;
         end else if (br) begin
            e_fl = 1;
         end
         chk($sformatf("model pc_write[%0d]", i), int'(pcw[i]), e_pc);
         chk($sformatf("model ifid_write[%0d]", i), int'(ifw[i]), e_iw);
         chk($sformatf("model bubble[%0d]", i), int'(bub[i]), e_bb);
         chk($sformatf("model flush[%0d]", i), int'(fl[i]), e_fl);
         if (rst) begin
            pend[i] = 0; mcnt[i] = 0;
         end else if (!ms && (pend[i] > 0 || hzm)) begin
            pend[i] = (pend[i] > 0) ? pend[i] - 1 : lat[i] - 1;
            if (mcnt[i] < cmax[i]) mcnt[i]++;
         end
      end
   endtask

   task automatic post();
      @(posedge clk);
      #1;
      chk("model cnt[0]", int'(cnt0), mcnt[0]);
      chk("model cnt[1]", int'(cnt1), mcnt[1]);
      chk("model cnt[2]", int'(cnt2), mcnt[2]);
   endtask

   task automatic cyc_l3(input string name, input int e_bb, input int e_pc);
      pre();
      chk({name, " bubble"}, int'(bub[1]), e_bb);
      chk({name, " pc_write"}, int'(pcw[1]), e_pc);
      post();
      @(negedge clk);
   endtask

   initial begin
      set_in(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin pend[i] = 0; mcnt[i] = 0; end

      //            rst rd rt s0 s1 v br ms   pc iw bb fl cnt
      tbl[0] = mk(1, 1, 8, 8, 0, 1, 0, 0,   1, 1, 0, 0, 0);
      tbl[1] = mk(0, 1, 8, 8, 0, 1, 0, 0,   0, 0, 1, 0, 1);
      tbl[2] = mk(0, 0, 8, 8, 0, 1, 0, 0,   1, 1, 0, 0, 1);
      tbl[3] = mk(0, 1, 0, 0, 0, 1, 0, 0,   1, 1, 0, 0, 1);
      tbl[4] = mk(0, 1, 8, 8, 0, 0, 0, 0,   1, 1, 0, 0, 1);
      tbl[5] = mk(0, 1, 9, 0, 9, 2, 1, 0,   0, 0, 1, 0, 2);
      tbl[6] = mk(0, 0, 9, 0, 9, 2, 1, 0,   1, 1, 0, 1, 2);
      tbl[7] = mk(0, 1, 8, 8, 0, 1, 0, 1,   0, 0, 0, 0, 2);
      tbl[8] = mk(0, 1, 8, 8, 0, 1, 0, 0,   0, 0, 1, 0, 3);

      @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         set_in(tbl[i].rst, tbl[i].rd, int'(tbl[i].rt), int'(tbl[i].s0), int'(tbl[i].s1),
                int'(tbl[i].v), tbl[i].br, tbl[i].ms);
         #1;
         chk($sformatf("tbl%0d pc_write", i), int'(pcw[0]), int'(tbl[i].pc));
         chk($sformatf("tbl%0d ifid_write", i), int'(ifw[0]), int'(tbl[i].iw));
         chk($sformatf("tbl%0d bubble", i), int'(bub[0]), int'(tbl[i].bb));
         chk($sformatf("tbl%0d flush", i), int'(fl[0]), int'(tbl[i].fl));
         pre();
         post();
         chk($sformatf("tbl%0d stall_cnt", i), int'(cnt0), tbl[i].cnt);
         @(negedge clk);
      end

      // LOAD_LAT=3: three bubbles even though the load leaves ID/EX after the first
      set_in(1, 0, 0, 0, 0, 0, 0, 0); cyc_l3("l3 reset", 0, 1);
      set_in(0, 1, 9, 0, 9, 2, 0, 0); cyc_l3("l3 b1", 1, 0);
      set_in(0, 0, 3, 0, 0, 0, 0, 0); cyc_l3("l3 b2", 1, 0);
      cyc_l3("l3 b3", 1, 0);
      cyc_l3("l3 done", 0, 1);
      chk("l3 stall_cnt", int'(cnt1), 3);

      // Freeze for two cycles in place of the second bubble
      set_in(1, 0, 0, 0, 0, 0, 0, 0); cyc_l3("fz reset", 0, 1);
      set_in(0, 1, 9, 0, 9, 2, 0, 0); cyc_l3("fz b1", 1, 0);
      set_in(0, 0, 3, 0, 0, 0, 0, 1); cyc_l3("fz f1", 0, 0);
      cyc_l3("fz f2", 0, 0);
      set_in(0, 0, 3, 0, 0, 0, 0, 0); cyc_l3("fz b2", 1, 0);
      cyc_l3("fz b3", 1, 0);
      cyc_l3("fz done", 0, 1);
      chk("fz stall_cnt", int'(cnt1), 3);

      // Reset while two bubbles are still owed
      set_in(0, 1, 9, 0, 9, 2, 0, 0); cyc_l3("rs b1", 1, 0);
      set_in(1, 0, 3, 0, 0, 0, 0, 0); cyc_l3("rs reset", 0, 1);
      chk("rs stall_cnt", int'(cnt1), 0);
      set_in(0, 0, 3, 0, 0, 0, 0, 0); cyc_l3("rs after", 0, 1);
      chk("rs stall_cnt after", int'(cnt1), 0);

      // Five hazards on the 2-bit counter
      for (int h = 0; h < 5; h++) begin
         set_in(0, 1, 4, 4, 0, 1, 0, 0); pre(); post(); @(negedge clk);
         set_in(0, 0, 0, 0, 0, 0, 0, 0);
         for (int k = 0; k < 3; k++) begin pre(); post(); @(negedge clk); end
      end
      chk("sat stall_cnt", int'(cnt2), 3);

      // Random traffic against the reference
      for (int n = 0; n < 400; n++) begin
         set_in(($urandom_range(31) == 0), ($urandom_range(1) == 1), int'($urandom_range(3)),
                int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(3)),
                ($urandom_range(3) == 0), ($urandom_range(7) == 0));
         pre(); post(); @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
